// File: rtl/ndn_content_producer.sv
// NDN content producer: a small content store looked up by longest matching
// name prefix; a hit streams a counted burst of seed-derived payload bytes.
module ndn_content_producer #(
  parameter int ENTRIES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ready_for_data,
  input  logic [63:0]                  longest_matching_prefix,
  input  logic [5:0]                   longest_matching_prefix_len,
  input  logic                         cfg_we,
  input  logic [$clog2(ENTRIES)-1:0]   cfg_idx,
  input  logic [63:0]                  cfg_prefix,
  input  logic [5:0]                   cfg_len,
  input  logic [7:0]                   cfg_count,
  input  logic [7:0]                   cfg_seed,
  output logic                         data_ready,
  output logic [63:0]                  data_in_prefix,
  output logic [5:0]                   data_in_len,
  output logic [7:0]                   in_data,
  output logic                         busy,
  output logic [15:0]                  hit_cnt,
  output logic [15:0]                  miss_cnt
);

  localparam int IW = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, LOOKUP, SEND, WAIT_DROP} state_t;

  state_t        state_q, state_d;
  logic          st_valid_q  [ENTRIES];
  logic          st_valid_d  [ENTRIES];
  logic [63:0]   st_prefix_q [ENTRIES];
  logic [63:0]   st_prefix_d [ENTRIES];
  logic [5:0]    st_len_q    [ENTRIES];
  logic [5:0]    st_len_d    [ENTRIES];
  logic [7:0]    st_count_q  [ENTRIES];
  logic [7:0]    st_count_d  [ENTRIES];
  logic [7:0]    st_seed_q   [ENTRIES];
  logic [7:0]    st_seed_d   [ENTRIES];

  logic [63:0]   req_prefix_q, req_prefix_d;
  logic [5:0]    req_len_q, req_len_d;
  logic [63:0]   w_prefix_q, w_prefix_d;
  logic [5:0]    w_len_q, w_len_d;
  logic [7:0]    w_count_q, w_count_d;
  logic [7:0]    w_seed_q, w_seed_d;
  logic [7:0]    k_q, k_d;
  logic [15:0]   hit_cnt_q, hit_cnt_d;
  logic [15:0]   miss_cnt_q, miss_cnt_d;
  logic          data_ready_q, data_ready_d;
  logic [63:0]   data_in_prefix_q, data_in_prefix_d;
  logic [5:0]    data_in_len_q, data_in_len_d;
  logic [7:0]    in_data_q, in_data_d;
  logic          busy_q, busy_d;

  logic          match_s [ENTRIES];
  logic          hit_s;
  logic [IW-1:0] best_s;
  logic [5:0]    best_len_s;

  // Longest-prefix selection over registered store contents; strict '>' keeps ties on the lowest index.
  always_comb begin
    hit_s      = 1'b0;
    best_s     = '0;
    best_len_s = 6'd0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_s[i] = st_valid_q[i] && (st_len_q[i] <= req_len_q) &&
                   (((st_prefix_q[i] ^ req_prefix_q) &
                     ~(64'hFFFF_FFFF_FFFF_FFFF >> st_len_q[i])) == 64'd0);
      best_s     = (match_s[i] && (!hit_s || (st_len_q[i] > best_len_s))) ? IW'(i) : best_s;
      best_len_s = (match_s[i] && (!hit_s || (st_len_q[i] > best_len_s))) ? st_len_q[i] : best_len_s;
      hit_s      = hit_s | match_s[i];
    end
  end

  // Next-state, store write, counters and registered output values.
  always_comb begin
    state_d          = state_q;
    st_valid_d       = st_valid_q;
    st_prefix_d      = st_prefix_q;
    st_len_d         = st_len_q;
    st_count_d       = st_count_q;
    st_seed_d        = st_seed_q;
    req_prefix_d     = req_prefix_q;
    req_len_d        = req_len_q;
    w_prefix_d       = w_prefix_q;
    w_len_d          = w_len_q;
    w_count_d        = w_count_q;
    w_seed_d         = w_seed_q;
    k_d              = k_q;
    hit_cnt_d        = hit_cnt_q;
    miss_cnt_d       = miss_cnt_q;
    data_ready_d     = 1'b0;
    data_in_prefix_d = 64'd0;
    data_in_len_d    = 6'd0;
    in_data_d        = 8'd0;

    if (cfg_we) begin
      st_valid_d[cfg_idx]  = (cfg_count != 8'd0);
      st_prefix_d[cfg_idx] = cfg_prefix;
      st_len_d[cfg_idx]    = cfg_len;
      st_count_d[cfg_idx]  = cfg_count;
      st_seed_d[cfg_idx]   = cfg_seed;
    end else begin
      st_valid_d = st_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (ready_for_data) begin
          req_prefix_d = longest_matching_prefix;
          req_len_d    = longest_matching_prefix_len;
          state_d      = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (!ready_for_data) begin
          state_d = IDLE;
        end else if (hit_s) begin
          w_prefix_d = st_prefix_q[best_s];
          w_len_d    = st_len_q[best_s];
          w_count_d  = st_count_q[best_s];
          w_seed_d   = st_seed_q[best_s];
          k_d        = 8'd0;
          hit_cnt_d  = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
          state_d    = SEND;
        end else begin
          miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
          state_d    = WAIT_DROP;
        end
      end
      SEND: begin
        if (!ready_for_data) begin
          state_d = IDLE;
        end else begin
          data_ready_d     = 1'b1;
          data_in_prefix_d = w_prefix_q;
          data_in_len_d    = w_len_q;
          in_data_d        = w_seed_q + k_q;
          k_d              = k_q + 8'd1;
          state_d          = (k_q == w_count_q - 8'd1) ? WAIT_DROP : SEND;
        end
      end
      WAIT_DROP: begin
        if (!ready_for_data) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DROP;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOOKUP) || (state_d == SEND);
  end

  // All state registers; reset clears the store, working copy, counters and outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      for (int i = 0; i < ENTRIES; i++) begin
        st_valid_q[i]  <= 1'b0;
        st_prefix_q[i] <= 64'd0;
        st_len_q[i]    <= 6'd0;
        st_count_q[i]  <= 8'd0;
        st_seed_q[i]   <= 8'd0;
      end
      req_prefix_q     <= 64'd0;
      req_len_q        <= 6'd0;
      w_prefix_q       <= 64'd0;
      w_len_q          <= 6'd0;
      w_count_q        <= 8'd0;
      w_seed_q         <= 8'd0;
      k_q              <= 8'd0;
      hit_cnt_q        <= 16'd0;
      miss_cnt_q       <= 16'd0;
      data_ready_q     <= 1'b0;
      data_in_prefix_q <= 64'd0;
      data_in_len_q    <= 6'd0;
      in_data_q        <= 8'd0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      st_valid_q       <= st_valid_d;
      st_prefix_q      <= st_prefix_d;
      st_len_q         <= st_len_d;
      st_count_q       <= st_count_d;
      st_seed_q        <= st_seed_d;
      req_prefix_q     <= req_prefix_d;
      req_len_q        <= req_len_d;
      w_prefix_q       <= w_prefix_d;
      w_len_q          <= w_len_d;
      w_count_q        <= w_count_d;
      w_seed_q         <= w_seed_d;
      k_q              <= k_d;
      hit_cnt_q        <= hit_cnt_d;
      miss_cnt_q       <= miss_cnt_d;
      data_ready_q     <= data_ready_d;
      data_in_prefix_q <= data_in_prefix_d;
      data_in_len_q    <= data_in_len_d;
      in_data_q        <= in_data_d;
      busy_q           <= busy_d;
    end
  end

  assign data_ready     = data_ready_q;
  assign data_in_prefix = data_in_prefix_q;
  assign data_in_len    = data_in_len_q;
  assign in_data        = in_data_q;
  assign busy           = busy_q;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_ndn_content_producer.sv
// Bench for ndn_content_producer: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ndn_content_producer;

  logic        clk = 1'b0;
  logic        rst, ready_for_data, cfg_we;
  logic [63:0] longest_matching_prefix, cfg_prefix;
  logic [5:0]  longest_matching_prefix_len, cfg_len;
  logic [1:0]  cfg_idx;
  logic [7:0]  cfg_count, cfg_seed;
  logic        data_ready, busy;
  logic [63:0] data_in_prefix;
  logic [5:0]  data_in_len;
  logic [7:0]  in_data;
  logic [15:0] hit_cnt, miss_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ndn_content_producer #(.ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .ready_for_data(ready_for_data),
    .longest_matching_prefix(longest_matching_prefix),
    .longest_matching_prefix_len(longest_matching_prefix_len),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_prefix(cfg_prefix), .cfg_len(cfg_len),
    .cfg_count(cfg_count), .cfg_seed(cfg_seed),
    .data_ready(data_ready), .data_in_prefix(data_in_prefix), .data_in_len(data_in_len),
    .in_data(in_data), .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    bit          v;
    logic [63:0] p;
    logic [5:0]  l;
    logic [7:0]  c;
    logic [7:0]  s;
  } ent_t;

  ent_t        m_st[4];
  bit          m_live = 1'b0;
  bit          m_pend, m_hold;
  logic [7:0]  m_q[$];
  logic [63:0] m_rp, m_name;
  logic [5:0]  m_rl, m_nlen;
  int          m_hits, m_miss;
  bit          e_dr, e_busy;
  logic [7:0]  e_data;
  logic [63:0] e_pre;
  logic [5:0]  e_len;

  function automatic bit pmatch(input logic [63:0] a, input logic [63:0] b, input int l);
    if (l == 0) return 1'b1;
    return (a >> (64 - l)) == (b >> (64 - l));
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_live = 1'b1;
        for (int i = 0; i < 4; i++) m_st[i].v = 1'b0;
        m_pend = 1'b0; m_hold = 1'b0; m_q.delete();
        m_hits = 0; m_miss = 0;
        e_dr = 1'b0; e_busy = 1'b0; e_data = 8'd0; e_pre = 64'd0; e_len = 6'd0;
      end else begin
        e_dr = 1'b0; e_data = 8'd0; e_pre = 64'd0; e_len = 6'd0;
        if (m_pend) begin
          m_pend = 1'b0;
          if (ready_for_data) begin
            int best;
            best = -1;
            for (int i = 0; i < 4; i++)
              if (m_st[i].v && m_st[i].l <= m_rl && pmatch(m_st[i].p, m_rp, int'(m_st[i].l)) &&
                  (best < 0 || m_st[i].l > m_st[best].l))
                best = i;
            if (best >= 0) begin
              if (m_hits < 65535) m_hits++;
              m_name = m_st[best].p; m_nlen = m_st[best].l;
              for (int k = 0; k < int'(m_st[best].c); k++) m_q.push_back(8'(m_st[best].s + k));
            end else begin
              if (m_miss < 65535) m_miss++;
              m_hold = 1'b1;
            end
          end
        end else if (m_q.size() > 0) begin
          if (ready_for_data) begin
            e_dr = 1'b1; e_data = m_q.pop_front(); e_pre = m_name; e_len = m_nlen;
            if (m_q.size() == 0) m_hold = 1'b1;
          end else begin
            m_q.delete();
          end
        end else if (m_hold) begin
          if (!ready_for_data) m_hold = 1'b0;
        end else if (ready_for_data) begin
          m_pend = 1'b1; m_rp = longest_matching_prefix; m_rl = longest_matching_prefix_len;
        end
        if (cfg_we) begin
          m_st[cfg_idx].v = (cfg_count != 8'd0);
          m_st[cfg_idx].p = cfg_prefix;
          m_st[cfg_idx].l = cfg_len;
          m_st[cfg_idx].c = cfg_count;
          m_st[cfg_idx].s = cfg_seed;
        end
        e_busy = m_pend || (m_q.size() > 0);
      end
    end
  end

  // Single compare process, on the falling edge once the model has seen a reset.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("data_ready", {63'd0, data_ready}, {63'd0, e_dr});
        chk("in_data", {56'd0, in_data}, {56'd0, e_data});
        chk("data_in_prefix", data_in_prefix, e_pre);
        chk("data_in_len", {58'd0, data_in_len}, {58'd0, e_len});
        chk("busy", {63'd0, busy}, {63'd0, e_busy});
        chk("hit_cnt", {48'd0, hit_cnt}, 64'(m_hits));
        chk("miss_cnt", {48'd0, miss_cnt}, 64'(m_miss));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cfg_write(input logic [1:0] idx, input logic [63:0] p, input logic [5:0] l,
                           input logic [7:0] c, input logic [7:0] s);
    cfg_we = 1'b1; cfg_idx = idx; cfg_prefix = p; cfg_len = l; cfg_count = c; cfg_seed = s;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    ready_for_data = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic request(input logic [63:0] p, input logic [5:0] l);
    longest_matching_prefix = p; longest_matching_prefix_len = l; ready_for_data = 1'b1;
  endtask

  task automatic drop();
    ready_for_data = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_dr(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL %s: data_ready never rose within 20 cycles, expected a burst", name);
    end
  endtask

  localparam logic [63:0] P_AB   = 64'hAB00_0000_0000_0000;
  localparam logic [63:0] P_ABCD = 64'hABCD_0000_0000_0000;
  localparam logic [63:0] P_CC   = 64'hCC00_0000_0000_0000;

  initial begin
    bit         ok;
    int         nbytes;
    logic [7:0] seen[3];

    rst = 1'b0; ready_for_data = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0;
    cfg_prefix = 64'd0; cfg_len = 6'd0; cfg_count = 8'd0; cfg_seed = 8'd0;
    longest_matching_prefix = 64'd0; longest_matching_prefix_len = 6'd0;
    do_reset();
    chk("reset_hit_cnt", {48'd0, hit_cnt}, 64'd0);
    chk("reset_data_ready", {63'd0, data_ready}, 64'd0);

    // Basic hit: bytes 10..13, len 8
    cfg_write(2'd0, P_AB, 6'd8, 8'd4, 8'h10);
    request(P_ABCD, 6'd16);
    wait_dr("basic_first", ok);
    chk("basic_b0", {56'd0, in_data}, 64'h10);
    chk("basic_len", {58'd0, data_in_len}, 64'd8);
    chk("basic_prefix", data_in_prefix, P_AB);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("basic_bk", {56'd0, in_data}, 64'(8'h10 + k));
    end
    @(negedge clk);
    chk("basic_end", {63'd0, data_ready}, 64'd0);
    chk("basic_hits", {48'd0, hit_cnt}, 64'd1);
    drop();

    // Longest match beats a len-0 catch-all
    do_reset();
    cfg_write(2'd1, 64'h1234_0000_0000_0000, 6'd0, 8'd2, 8'h20);
    cfg_write(2'd2, P_AB, 6'd8, 8'd2, 8'h30);
    request(P_ABCD, 6'd16);
    wait_dr("longest", ok);
    chk("longest_b0", {56'd0, in_data}, 64'h30);
    drop();

    // Equal lengths: lower index wins
    do_reset();
    cfg_write(2'd1, P_AB, 6'd8, 8'd2, 8'h40);
    cfg_write(2'd3, P_AB, 6'd8, 8'd2, 8'h50);
    request(P_ABCD, 6'd16);
    wait_dr("tie", ok);
    chk("tie_b0", {56'd0, in_data}, 64'h40);
    drop();

    // Miss, then an entry longer than the request also misses
    do_reset();
    cfg_write(2'd0, P_CC, 6'd8, 8'd4, 8'h10);
    request(P_AB, 6'd8);
    @(negedge clk);
    chk("miss_busy1", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("miss_busy0", {63'd0, busy}, 64'd0);
    chk("miss_cnt1", {48'd0, miss_cnt}, 64'd1);
    repeat (4) @(negedge clk);
    chk("miss_no_dr", {63'd0, data_ready}, 64'd0);
    drop();
    cfg_write(2'd1, P_AB, 6'd8, 8'd2, 8'h10);
    request(P_AB, 6'd4);
    repeat (4) @(negedge clk);
    chk("miss_shortreq", {48'd0, miss_cnt}, 64'd2);
    drop();

    // Wrap and hold: exactly one burst FE,FF,00
    do_reset();
    cfg_write(2'd0, P_AB, 6'd8, 8'd3, 8'hFE);
    request(P_AB, 6'd8);
    nbytes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (data_ready) begin
        if (nbytes < 3) seen[nbytes] = in_data;
        nbytes++;
      end
    end
    chk("wrap_count", 64'(nbytes), 64'd3);
    chk("wrap_b0", {56'd0, seen[0]}, 64'hFE);
    chk("wrap_b1", {56'd0, seen[1]}, 64'hFF);
    chk("wrap_b2", {56'd0, seen[2]}, 64'h00);
    drop();

    // Abort by dropping the request after byte 2
    cfg_write(2'd0, P_AB, 6'd8, 8'd8, 8'h00);
    request(P_AB, 6'd8);
    wait_dr("abort", ok);
    repeat (2) @(negedge clk);
    chk("abort_b2", {56'd0, in_data}, 64'h02);
    ready_for_data = 1'b0;
    @(negedge clk);
    chk("abort_dr", {63'd0, data_ready}, 64'd0);
    chk("abort_data", {56'd0, in_data}, 64'd0);
    @(negedge clk);

    // Reset at byte 2: outputs clear, store empties, the held request then misses
    request(P_AB, 6'd8);
    wait_dr("rstmid", ok);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rstmid_dr", {63'd0, data_ready}, 64'd0);
    chk("rstmid_data", {56'd0, in_data}, 64'd0);
    chk("rstmid_hits", {48'd0, hit_cnt}, 64'd0);
    repeat (3) @(negedge clk);
    chk("rstmid_miss", {48'd0, miss_cnt}, 64'd1);
    drop();

    // Config rewrite of the active entry mid-burst
    cfg_write(2'd0, P_AB, 6'd8, 8'd4, 8'h10);
    request(P_AB, 6'd8);
    wait_dr("cfgsend", ok);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_prefix = P_AB; cfg_len = 6'd8; cfg_count = 8'd4; cfg_seed = 8'h80;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfgsend_b1", {56'd0, in_data}, 64'h11);
    repeat (2) @(negedge clk);
    chk("cfgsend_b3", {56'd0, in_data}, 64'h13);
    drop();
    request(P_AB, 6'd8);
    wait_dr("cfgsend_next", ok);
    chk("cfgsend_new", {56'd0, in_data}, 64'h80);
    drop();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ndn_content_producer.md
NDN_CONTENT_PRODUCER -- requirements
Module: ndn_content_producer

Interface
REQ-001 SHALL take parameter ENTRIES, default 4, the number of content-store entries (index width 2).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst, input, 1, reset; synchronous, active-low.
REQ-004 SHALL provide port ready_for_data, input, 1, level request from the router forwarding side.
REQ-005 SHALL provide port longest_matching_prefix, input, 64, the requested name prefix, MSB-aligned.
REQ-006 SHALL provide port longest_matching_prefix_len, input, 6, the number of significant prefix bits counted from bit 63.
REQ-007 SHALL provide port cfg_we, input, 1, the content-store write strobe.
REQ-008 SHALL provide ports cfg_idx (input, 2), cfg_prefix (input, 64), cfg_len (input, 6), cfg_count (input, 8) and cfg_seed (input, 8), the entry write fields.
REQ-009 SHALL provide port data_ready, output, 1, high on every payload-byte cycle.
REQ-010 SHALL provide ports data_in_prefix (output, 64) and data_in_len (output, 6), the name of the entry being served.
REQ-011 SHALL provide port in_data, output, 8, the payload byte.
REQ-012 SHALL provide ports busy (output, 1), hit_cnt (output, 16) and miss_cnt (output, 16), for status.

Function
REQ-013 SHALL write all entry fields on any edge where cfg_we=1:
- Fields written: valid, prefix, len, count, seed, at index cfg_idx.
- valid = (cfg_count != 0).
REQ-014 SHALL use the following FSM states: IDLE, LOOKUP, SEND, WAIT_DROP.
REQ-015 SHALL go IDLE->LOOKUP on the first edge with ready_for_data=1, and latch the request prefix and len on that edge.
REQ-016 SHALL evaluate matches in LOOKUP against the store contents from before any same-edge cfg write:
- An entry matches when it is valid, entry.len <= req.len, and prefix bits [63:64-entry.len] are equal.
- entry.len=0 matches any request.
REQ-017 SHALL pick, among matching entries, the one with the largest len; ties go to the lowest index.
REQ-018 SHALL handle a LOOKUP hit as follows:
- Copy prefix, len, count and seed into working registers.
- Increment hit_cnt.
- Go to SEND.
REQ-019 SHALL handle a LOOKUP miss by incrementing miss_cnt and going to WAIT_DROP; no data_ready is produced.
REQ-020 SHALL drive the following in SEND:
- data_ready=1.
- data_in_prefix and data_in_len from the working registers, stable for the whole burst.
- in_data = (seed + k) mod 256 on burst cycle k, where k = 0..count-1.
REQ-021 SHALL fix latency: request sampled at edge E puts byte 0 on the outputs after edge E+2; the last byte appears after edge E+1+count.
REQ-022 SHALL go SEND->WAIT_DROP after byte count-1.
REQ-023 SHALL go WAIT_DROP->IDLE on the first edge with ready_for_data=0; a request held high never re-triggers.
REQ-024 SHALL abort when ready_for_data=0 is sampled in SEND or LOOKUP:
- data_ready=0 from the next edge.
- Go to IDLE.
- hit_cnt is still counted if the abort happens after LOOKUP.
REQ-025 SHALL isolate a running burst from cfg writes during SEND, including writes to the entry being served; the burst uses only the working copy.
REQ-026 SHALL drive in_data, data_in_prefix and data_in_len to 0 whenever data_ready=0.
REQ-027 SHALL saturate hit_cnt and miss_cnt at 16'hFFFF.
REQ-028 SHALL drive busy=1 in LOOKUP and SEND, and 0 otherwise.

Reset
REQ-029 SHALL apply the following on any edge with rst=0:
- State goes to IDLE.
- All entries become invalid.
- Working registers, hit_cnt and miss_cnt are cleared to 0.
- Outputs are 0 from the following cycle.
REQ-030 SHALL apply reset even mid-burst: data_ready falls on the reset edge and no further bytes are produced.
REQ-031 SHALL ignore cfg_we and ready_for_data while rst=0.

Verification
REQ-032 Basic hit:
- Stimulus: entry0={prefix 64'hAB00..0, len 8, count 4, seed 8'h10}; request 64'hABCD..0, len 16.
- Response: data_ready for 4 cycles; in_data 10,11,12,13; data_in_len=8; hit_cnt=1.
REQ-033 Longest match:
- Stimulus: entry1 len 0 (default) and entry2 {prefix AB.., len 8}, both matching.
- Response: entry2 served.
- Second stimulus: identical len entries at indices 1 and 3.
- Second response: index 1 served.
REQ-034 Miss:
- Stimulus: only entry {prefix 64'hCC00..0, len 8}; request 64'hAB00..0.
- Response: no data_ready; miss_cnt=1; busy back to 0 two cycles after the request.
REQ-035 Wrap and hold:
- Stimulus: count 3, seed 8'hFE; ready_for_data held high 10 cycles.
- Response: in_data FE,FF,00; exactly one burst.
REQ-036 Abort/reset mid-burst:
- Stimulus: count 8; ready_for_data dropped after byte 2.
- Response: data_ready low next cycle.
- Repeat with rst=0 at byte 2: all outputs 0; entries invalid (a subsequent request misses).
REQ-037 Config during SEND:
- Stimulus: rewrite the active entry's seed mid-burst.
- Response: the burst keeps its old seed; the next request uses the new seed.
